// File: rtl/audio_pkg.sv
// Shared constants, state encoding and sample helpers for the codec ADC receive path.
package audio_pkg;

    localparam int   SAMPLE_W = 16;
    localparam logic MODE_LJ  = 1'b0;
    localparam logic MODE_I2S = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_LEFT      = 2'd1,
        ST_RIGHT     = 2'd2
    } rx_state_e;

    // Magnitude of a two's-complement sample; the most negative code clamps to full scale.
    function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-2:0] neg;
        neg = (~s[SAMPLE_W-2:0]) + {{(SAMPLE_W-2){1'b0}}, 1'b1};
        if (!s[SAMPLE_W-1]) begin
            abs_sat = s[SAMPLE_W-2:0];
        end else if (s[SAMPLE_W-2:0] == {(SAMPLE_W-1){1'b0}}) begin
            abs_sat = {(SAMPLE_W-1){1'b1}};
        end else begin
            abs_sat = neg;
        end
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect on one lane; the plain lanes share
// the same two-flop delay so they stay aligned with the detected edge.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         edge_in,
    input  logic [W-1:0] data_in,
    output logic         rise,
    output logic [W-1:0] data_out
);

    logic         e1_q, e2_q, e3_q;
    logic         e1_d, e2_d, e3_d;
    logic [W-1:0] d1_q, d2_q;
    logic [W-1:0] d1_d, d2_d;

    // next-state of the synchronizer chains
    always_comb begin
        e1_d = edge_in;
        e2_d = e1_q;
        e3_d = e2_q;
        d1_d = data_in;
        d2_d = d1_q;
    end

    // synchronizer flops
    always_ff @(posedge clk) begin
        if (reset) begin
            e1_q <= 1'b0;
            e2_q <= 1'b0;
            e3_q <= 1'b0;
            d1_q <= {W{1'b0}};
            d2_q <= {W{1'b0}};
        end else begin
            e1_q <= e1_d;
            e2_q <= e2_d;
            e3_q <= e3_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
        end
    end

    assign rise     = e2_q & ~e3_q;
    assign data_out = d2_q;

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: deserializes 16-bit left/right samples from the BCLK/LRCK/DAT
// stream, publishes complete frames on sample_valid and tracks a windowed left-channel peak.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter logic I2S_MODE   = 1'b1,
    parameter logic LEFT_LRCK  = 1'b0,
    parameter int   WIN_FRAMES = 4800
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                AUD_BCLK,
    input  logic                AUD_ADCLRCK,
    input  logic                AUD_ADCDAT,
    output logic [SAMPLE_W-1:0] left_sample,
    output logic [SAMPLE_W-1:0] right_sample,
    output logic                sample_valid,
    output logic [7:0]          level,
    output logic                frame_err
);

    localparam int CNT_W  = $clog2(WIN_FRAMES + 1);
    localparam int PEAK_W = SAMPLE_W - 1;

    logic                rise_s, lrck_s, dat_s, slot_edge_s;
    logic [1:0]          sync_s;
    logic [SAMPLE_W-1:0] shift_in_s;
    logic [PEAK_W-1:0]   abs_s, peak_new_s;

    rx_state_e           state_q, state_d;
    logic                lrck_prev_q, lrck_prev_d, prev_valid_q, prev_valid_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_shadow_q, left_shadow_d, right_shadow_q, right_shadow_d;
    logic                left_good_q, left_good_d, done_q, done_d;
    logic [SAMPLE_W-1:0] left_sample_q, left_sample_d, right_sample_q, right_sample_d;
    logic                sample_valid_q, sample_valid_d, frame_err_q, frame_err_d;
    logic [PEAK_W-1:0]   peak_q, peak_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [7:0]          level_q, level_d;

    sync_edge #(.W(2)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .edge_in  (AUD_BCLK),
        .data_in  ({AUD_ADCDAT, AUD_ADCLRCK}),
        .rise     (rise_s),
        .data_out (sync_s)
    );

    assign lrck_s = sync_s[0];
    assign dat_s  = sync_s[1];

    // slot tracking and bit capture on each synchronized BCLK rise
    always_comb begin
        state_d        = state_q;
        lrck_prev_d    = lrck_prev_q;
        prev_valid_d   = prev_valid_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        left_shadow_d  = left_shadow_q;
        right_shadow_d = right_shadow_q;
        left_good_d    = left_good_q;
        frame_err_d    = frame_err_q;
        done_d         = 1'b0;
        slot_edge_s    = rise_s & prev_valid_q & (lrck_s ^ lrck_prev_q);
        shift_in_s     = {shift_q[SAMPLE_W-2:0], dat_s};
        if (rise_s) begin
            prev_valid_d = 1'b1;
            lrck_prev_d  = lrck_s;
            if (slot_edge_s) begin
                case (state_q)
                    ST_LEFT: begin
                        if (bit_cnt_q == 5'd16) begin
                            left_shadow_d = shift_q;
                            left_good_d   = 1'b1;
                        end else begin
                            left_good_d   = 1'b0;
                            frame_err_d   = 1'b1;
                        end
                    end
                    ST_RIGHT: begin
                        // a full right slot was already published on its 16th bit
                        if (bit_cnt_q != 5'd16) begin
                            frame_err_d = 1'b1;
                        end else begin
                            frame_err_d = frame_err_q;
                        end
                    end
                    default: begin
                        frame_err_d = frame_err_q;
                    end
                endcase
                if (lrck_s == LEFT_LRCK) begin
                    state_d = ST_LEFT;
                end else if (state_q == ST_WAIT_SYNC) begin
                    state_d = ST_WAIT_SYNC;
                end else begin
                    state_d = ST_RIGHT;
                end
                if (I2S_MODE == MODE_I2S) begin
                    bit_cnt_d = 5'd0;
                end else begin
                    bit_cnt_d = 5'd1;
                    shift_d   = shift_in_s;
                end
            end else if ((state_q != ST_WAIT_SYNC) && (bit_cnt_q < 5'd16)) begin
                shift_d   = shift_in_s;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if ((state_q == ST_RIGHT) && (bit_cnt_q == 5'd15)) begin
                    right_shadow_d = shift_in_s;
                    done_d         = left_good_q;
                end else begin
                    done_d         = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            prev_valid_d = prev_valid_q;
        end
    end

    // frame publish and windowed peak of the left channel
    always_comb begin
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        sample_valid_d = 1'b0;
        peak_d         = peak_q;
        frame_cnt_d    = frame_cnt_q;
        level_d        = level_q;
        abs_s          = abs_sat(left_shadow_q);
        peak_new_s     = (abs_s > peak_q) ? abs_s : peak_q;
        if (done_q) begin
            left_sample_d  = left_shadow_q;
            right_sample_d = right_shadow_q;
            sample_valid_d = 1'b1;
            // closing frame of a window: fold the new sample in before publishing
            if (frame_cnt_q == CNT_W'(WIN_FRAMES - 1)) begin
                level_d     = peak_new_s[PEAK_W-1 -: 8];
                peak_d      = {PEAK_W{1'b0}};
                frame_cnt_d = {CNT_W{1'b0}};
            end else begin
                peak_d      = peak_new_s;
                frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            sample_valid_d = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_WAIT_SYNC;
            lrck_prev_q    <= 1'b0;
            prev_valid_q   <= 1'b0;
            bit_cnt_q      <= 5'd0;
            shift_q        <= {SAMPLE_W{1'b0}};
            left_shadow_q  <= {SAMPLE_W{1'b0}};
            right_shadow_q <= {SAMPLE_W{1'b0}};
            left_good_q    <= 1'b0;
            done_q         <= 1'b0;
            left_sample_q  <= {SAMPLE_W{1'b0}};
            right_sample_q <= {SAMPLE_W{1'b0}};
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            peak_q         <= {PEAK_W{1'b0}};
            frame_cnt_q    <= {CNT_W{1'b0}};
            level_q        <= 8'd0;
        end else begin
            state_q        <= state_d;
            lrck_prev_q    <= lrck_prev_d;
            prev_valid_q   <= prev_valid_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            left_shadow_q  <= left_shadow_d;
            right_shadow_q <= right_shadow_d;
            left_good_q    <= left_good_d;
            done_q         <= done_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            peak_q         <= peak_d;
            frame_cnt_q    <= frame_cnt_d;
            level_q        <= level_d;
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = sample_valid_q;
    assign level        = level_q;
    assign frame_err    = frame_err_q;

endmodule
